pc_ras: RTL and testbench

- Parametrised program-counter unit: next-generation instruction-fetch PC with a configurable width, increment step, reset vector and flush delay.
- Adds call/return modes backed by a circular return-address stack (RAS).
- Sits between the decode/branch unit, which drives pc_valid/pc_mode/pc_data, and the instruction memory address port, which consumes pc_out.
- jump_finish tells the fetch stage when a redirect's flush window has elapsed.

---
 rtl/pc_ras.sv | 142 ++++++++++++++
 tb/tb_pc_ras.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pc_ras.sv
// Instruction-fetch program counter with call/return support backed by a circular
// return-address stack, plus a flush countdown that pulses jump_finish after redirects.
module pc_ras #(
    parameter int unsigned     W            = 32,
    parameter int unsigned     STEP         = 1,
    parameter logic [W-1:0]    RESET_VECTOR = '0,
    parameter int unsigned     DEPTH        = 8,
    parameter int unsigned     FLUSH_DELAY  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pc_valid,
    input  logic [2:0]                 pc_mode,
    input  logic [W-1:0]               pc_data,
    output logic [W-1:0]               pc_out,
    output logic                       jump_finish,
    output logic                       flush_busy,
    output logic [$clog2(DEPTH+1)-1:0] ras_count,
    output logic                       ras_overflow,
    output logic                       ras_underflow
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int FLW   = $clog2(FLUSH_DELAY + 1);

    localparam logic [2:0] MODE_INC = 3'd0;
    localparam logic [2:0] MODE_ABS = 3'd1;
    localparam logic [2:0] MODE_REL = 3'd2;
    localparam logic [2:0] MODE_CALL = 3'd3;
    localparam logic [2:0] MODE_RET = 3'd4;

    logic [W-1:0]     ras_mem [DEPTH];
    logic [W-1:0]     pc_q, pc_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [FLW-1:0]   flush_cnt_q, flush_cnt_d;
    logic             jump_finish_q, jump_finish_d;
    logic             flush_busy_q, flush_busy_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [W-1:0]     link;
    logic [PTR_W-1:0] top_idx, next_idx;
    logic             push, redirect;

    assign link     = pc_q + W'(STEP);
    assign top_idx  = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - 1'b1;
    assign next_idx = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;

    always_comb begin
        pc_d          = pc_q;
        ptr_d         = ptr_q;
        count_d       = count_q;
        ovf_d         = ovf_q;
        unf_d         = unf_q;
        push          = 1'b0;
        redirect      = 1'b0;
        flush_cnt_d   = flush_cnt_q;
        jump_finish_d = 1'b0;
        flush_busy_d  = flush_busy_q;

        if (pc_valid) begin
            case (pc_mode)
                MODE_INC: pc_d = link;
                MODE_ABS: begin
                    pc_d     = pc_data;
                    redirect = 1'b1;
                end
                MODE_REL: begin
                    // Two's-complement add wraps identically to unsigned add at W bits.
                    pc_d     = pc_q + pc_data;
                    redirect = 1'b1;
                end
                MODE_CALL: begin
                    pc_d     = pc_data;
                    push     = 1'b1;
                    redirect = 1'b1;
                    ptr_d    = next_idx;
                    if (count_q == CNT_W'(DEPTH)) ovf_d = 1'b1;
                    else                          count_d = count_q + 1'b1;
                end
                MODE_RET: begin
                    if (count_q != '0) begin
                        pc_d     = ras_mem[top_idx];
                        ptr_d    = top_idx;
                        count_d  = count_q - 1'b1;
                        redirect = 1'b1;
                    end else begin
                        pc_d  = link;
                        unf_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // A new redirect supersedes any pending countdown, even on its expiry edge.
        if (redirect) begin
            flush_cnt_d  = FLW'(FLUSH_DELAY);
            flush_busy_d = 1'b1;
        end else if (flush_cnt_q != '0) begin
            flush_cnt_d = flush_cnt_q - 1'b1;
            if (flush_cnt_q == FLW'(1)) begin
                jump_finish_d = 1'b1;
                flush_busy_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_VECTOR;
            ptr_q         <= '0;
            count_q       <= '0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
            flush_cnt_q   <= '0;
            jump_finish_q <= 1'b0;
            flush_busy_q  <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            ptr_q         <= ptr_d;
            count_q       <= count_d;
            ovf_q         <= ovf_d;
            unf_q         <= unf_d;
            flush_cnt_q   <= flush_cnt_d;
            jump_finish_q <= jump_finish_d;
            flush_busy_q  <= flush_busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) ras_mem[ptr_q] <= link;
    end

    assign pc_out        = pc_q;
    assign jump_finish   = jump_finish_q;
    assign flush_busy    = flush_busy_q;
    assign ras_count     = count_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
endmodule

// File: tb/tb_pc_ras.sv
// Self-checking bench for pc_ras: directed scenarios followed by random traffic,
// compared every cycle against a queue-based reference model.
module tb_pc_ras;
    localparam int          W   = 32;
    localparam int          STP = 1;
    localparam logic [31:0] RV  = 32'h100;
    localparam int          DEP = 8;
    localparam int          FD  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_valid = 1'b0;
    logic [2:0]  pc_mode = 3'd0;
    logic [31:0] pc_data = '0;
    logic [31:0] pc_out;
    logic        jump_finish, flush_busy, ras_overflow, ras_underflow;
    logic [3:0]  ras_count;

    pc_ras #(.W(W), .STEP(STP), .RESET_VECTOR(RV), .DEPTH(DEP), .FLUSH_DELAY(FD)) dut (
        .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc_mode(pc_mode), .pc_data(pc_data),
        .pc_out(pc_out), .jump_finish(jump_finish), .flush_busy(flush_busy),
        .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stack as a bounded queue, flush as a deadline in edge numbers.
    logic [31:0] m_pc = RV;
    logic [31:0] m_ras[$];
    bit          m_ovf = 0, m_unf = 0, m_jf = 0, m_pending = 0;
    int          m_last = 0;
    int          edge_n = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h, expected %h", tag, edge_n, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [2:0] m, input logic [31:0] d);
        bit redir;
        rst = r; pc_valid = v; pc_mode = m; pc_data = d;
        @(posedge clk);
        edge_n++;
        redir = 0;
        if (r) begin
            m_pc = RV; m_ras.delete(); m_ovf = 0; m_unf = 0; m_jf = 0; m_pending = 0;
        end else begin
            if (v) begin
                case (m)
                    3'd0: m_pc = m_pc + STP;
                    3'd1: begin m_pc = d; redir = 1; end
                    3'd2: begin m_pc = 32'($signed(m_pc) + $signed(d)); redir = 1; end
                    3'd3: begin
                        m_ras.push_back(m_pc + STP);
                        if (m_ras.size() > DEP) begin
                            void'(m_ras.pop_front());
                            m_ovf = 1;
                        end
                        m_pc = d; redir = 1;
                    end
                    3'd4: begin
                        if (m_ras.size() > 0) begin
                            m_pc = m_ras.pop_back(); redir = 1;
                        end else begin
                            m_pc = m_pc + STP; m_unf = 1;
                        end
                    end
                    default: ;
                endcase
            end
            m_jf = m_pending && !redir && (edge_n == m_last + FD);
            if (m_jf) m_pending = 0;
            if (redir) begin m_pending = 1; m_last = edge_n; end
        end
        #1;
        $display("[TB] edge %0d rst=%0d v=%0d mode=%0d data=%h -> pc=%h jf=%0d busy=%0d cnt=%0d ovf=%0d unf=%0d",
                 edge_n, r, v, m, d, pc_out, jump_finish, flush_busy, ras_count, ras_overflow, ras_underflow);
        check("pc_out", pc_out, m_pc);
        check("jump_finish", 32'(jump_finish), 32'(m_jf));
        check("flush_busy", 32'(flush_busy), 32'(m_pending));
        check("ras_count", 32'(ras_count), 32'(m_ras.size()));
        check("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
        check("ras_underflow", 32'(ras_underflow), 32'(m_unf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 3'd0, '0);
    endtask

    initial begin
        // Reset and sequential fetch
        step(1, 0, 3'd0, '0);
        step(1, 1, 3'd1, 32'hDEAD);
        check("reset_vector", pc_out, 32'h100);
        for (int i = 0; i < 4; i++) step(0, 1, 3'd0, '0);
        check("inc_x4", pc_out, 32'h104);

        // Relative jumps, including backwards and wrapping
        step(0, 1, 3'd1, 32'h10);
        idle(4);
        step(0, 1, 3'd2, 32'hFFFF_FFFC);
        check("rel_back", pc_out, 32'h0C);
        idle(4);
        step(0, 1, 3'd1, 32'hFFFF_FFFE);
        step(0, 1, 3'd2, 32'h4);
        check("rel_wrap", pc_out, 32'h2);
        idle(4);

        // Nested calls, returns, underflow
        step(0, 1, 3'd1, 32'h20);
        step(0, 1, 3'd3, 32'h400);
        step(0, 1, 3'd3, 32'h800);
        check("nest_cnt", 32'(ras_count), 32'd2);
        step(0, 1, 3'd4, '0);
        check("ret1", pc_out, 32'h401);
        step(0, 1, 3'd4, '0);
        check("ret2", pc_out, 32'h21);
        idle(4);
        step(0, 1, 3'd4, '0);
        check("ret_empty", pc_out, 32'h22);
        idle(4);

        // Overflow: nine calls, eight returns
        for (int i = 0; i < 9; i++) step(0, 1, 3'd3, 32'h1000 * (i + 1));
        check("ovf_cnt", 32'(ras_count), 32'd8);
        for (int i = 0; i < 8; i++) step(0, 1, 3'd4, '0);
        check("ovf_last_ret", pc_out, 32'h1001);
        idle(4);

        // Superseding redirect inside the flush window
        step(0, 1, 3'd1, 32'h3000);
        step(0, 0, 3'd0, '0);
        step(0, 1, 3'd1, 32'h4000);
        idle(6);
        // Reload coinciding with the expiry edge
        step(0, 1, 3'd1, 32'h5000);
        idle(2);
        step(0, 1, 3'd1, 32'h6000);
        idle(5);

        // Reset during a countdown with three stacked entries
        for (int i = 0; i < 3; i++) step(0, 1, 3'd3, 32'h7000 + i);
        step(1, 1, 3'd0, '0);
        check("rst_cnt", 32'(ras_count), 32'd0);
        idle(5);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            logic r, v;
            logic [2:0] m;
            logic [31:0] d;
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 3) != 0);
            m = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) m = 3'($urandom_range(3, 4));
            d = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($signed($urandom_range(0, 64)) - 32);
            step(r, v, m, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
